seq_scan_sched: RTL and testbench

- Round-robin scheduler that shares one serial sequence detector between NREQ requesters.
- Each requester presents a parallel WORD_W-bit word. The granted word is shifted into the detector MSB-first, one bit per clock.
- Overlapping occurrences of a PAT_LEN-bit pattern are counted; the count is returned with a done pulse and the requester ID.
- Sits in front of the FSM sequence-detector datapath as its sequencer and arbiter.

---
 rtl/seq_scan_sched_pkg.sv | 19 +
 rtl/seq_scan_sched_if.sv | 51 +++++
 rtl/seq_scan_sched_rr_arbiter.sv | 35 +++
 rtl/seq_scan_sched.sv | 134 +++++++++++++
 tb/tb_seq_scan_sched.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/seq_scan_sched_pkg.sv
// Shared types and default sizing for the round-robin sequence-scan scheduler.
// Holds the FSM state encoding and the default NREQ/WORD_W/PAT_LEN values.
package seq_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } sched_state_t;

    localparam int NREQ_DEF    = 4;
    localparam int WORD_W_DEF  = 8;
    localparam int PAT_LEN_DEF = 4;

    // Count must hold WORD_W-PAT_LEN+1; bit index must reach WORD_W.
    localparam int CNT_W_DEF = $clog2(WORD_W_DEF + 1);
    localparam int ID_W_DEF  = $clog2(NREQ_DEF);

endpackage

// File: rtl/seq_scan_sched_if.sv
// Requester-side bus of the scan scheduler.
// master: requesters (drive req/word_in/pattern); slave: the scheduler.
interface seq_scan_sched_if #(
    parameter int NREQ    = seq_sched_pkg::NREQ_DEF,
    parameter int WORD_W  = seq_sched_pkg::WORD_W_DEF,
    parameter int PAT_LEN = seq_sched_pkg::PAT_LEN_DEF
);
    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = $clog2(WORD_W + 1);

    logic [NREQ-1:0]        req;
    logic [NREQ*WORD_W-1:0] word_in;
    logic [PAT_LEN-1:0]     pattern;
    logic [NREQ-1:0]        gnt;
    logic                   busy;
    logic                   bit_valid;
    logic                   bit_out;
    logic                   match_pulse;
    logic                   done;
    logic [ID_W-1:0]        done_id;
    logic [CNT_W-1:0]       match_cnt;

    modport master (
        output req,
        output word_in,
        output pattern,
        input  gnt,
        input  busy,
        input  bit_valid,
        input  bit_out,
        input  match_pulse,
        input  done,
        input  done_id,
        input  match_cnt
    );

    modport slave (
        input  req,
        input  word_in,
        input  pattern,
        output gnt,
        output busy,
        output bit_valid,
        output bit_out,
        output match_pulse,
        output done,
        output done_id,
        output match_cnt
    );

endinterface

// File: rtl/seq_scan_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set req bit at or above ptr_i, wrapping.
// Ports: req_i, ptr_i in; winner_o (index), valid_o (any request) out.
module rr_arbiter #(
    parameter int NREQ = seq_sched_pkg::NREQ_DEF,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [ID_W-1:0] winner_o,
    output logic            valid_o
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_i} + (ID_W + 1)'(k);
            if (int'(sum) >= NREQ) begin
                sum = sum - (ID_W + 1)'(NREQ);
            end
            idx = sum[ID_W-1:0];
            if (req_i[idx]) begin
                winner_o = idx;
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_scan_sched.sv
// Round-robin scheduler sharing one serial overlapping-pattern detector.
// Ports: clk, reset (async, active-high); bus (slave) carries req/word/pattern
// in and gnt/busy/bit stream/match_pulse/done/done_id/match_cnt out.
module seq_scan_sched
    import seq_sched_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int WORD_W  = WORD_W_DEF,
    parameter int PAT_LEN = PAT_LEN_DEF
) (
    input  logic             clk,
    input  logic             reset,
    seq_scan_sched_if.slave  bus
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam int HW    = PAT_LEN - 1;

    sched_state_t     state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  cur_id_q, cur_id_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] bit_idx_q, bit_idx_d;
    logic [WORD_W-1:0] word_sr_q, word_sr_d;
    logic [HW-1:0]    hist_q, hist_d;
    logic [PAT_LEN-1:0] pat_q, pat_d;

    logic [ID_W-1:0] winner;
    logic            win_vld;
    logic            scan;
    logic            cur_bit;
    logic            match;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req_i    (bus.req),
        .ptr_i    (rr_ptr_q),
        .winner_o (winner),
        .valid_o  (win_vld)
    );

    assign scan    = (state_q == SCAN);
    assign cur_bit = word_sr_q[WORD_W-1];

    // History holds the previous PAT_LEN-1 bits of this word only,
    // so the index gate stops a match straddling the grant.
    assign match = scan
                && (int'(bit_idx_q) >= PAT_LEN - 1)
                && ({hist_q, cur_bit} == pat_q);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cur_id_d    = cur_id_q;
        gnt_d       = '0;
        match_cnt_d = match_cnt_q;
        bit_idx_d   = bit_idx_q;
        word_sr_d   = word_sr_q;
        hist_d      = hist_q;
        pat_d       = pat_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d     = SCAN;
                    word_sr_d   = bus.word_in[winner*WORD_W +: WORD_W];
                    pat_d       = bus.pattern;
                    cur_id_d    = winner;
                    match_cnt_d = '0;
                    bit_idx_d   = '0;
                    hist_d      = '0;
                    gnt_d       = NREQ'(1) << winner;
                    if (int'(winner) == NREQ - 1) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = winner + ID_W'(1);
                    end
                end
            end
            SCAN: begin
                word_sr_d   = word_sr_q << 1;
                hist_d      = HW'({hist_q, cur_bit});
                bit_idx_d   = bit_idx_q + CNT_W'(1);
                match_cnt_d = match_cnt_q + CNT_W'(match);
                if (int'(bit_idx_q) == WORD_W - 1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cur_id_q    <= '0;
            gnt_q       <= '0;
            match_cnt_q <= '0;
            bit_idx_q   <= '0;
            word_sr_q   <= '0;
            hist_q      <= '0;
            pat_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_id_q    <= cur_id_d;
            gnt_q       <= gnt_d;
            match_cnt_q <= match_cnt_d;
            bit_idx_q   <= bit_idx_d;
            word_sr_q   <= word_sr_d;
            hist_q      <= hist_d;
            pat_q       <= pat_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.bit_valid   = scan;
    assign bus.bit_out     = scan & cur_bit;
    assign bus.match_pulse = match;
    assign bus.done        = (state_q == DONE);
    assign bus.done_id     = cur_id_q;
    assign bus.match_cnt   = match_cnt_q;

endmodule

// File: tb/tb_seq_scan_sched.sv
// Directed testbench for seq_scan_sched (NREQ=4, WORD_W=8, PAT_LEN=4).
// Drives the requester bus and checks grant, serial stream, matches and done.
module tb_seq_scan_sched;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    seq_scan_sched_if bus ();

    seq_scan_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_words(input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] w2, input logic [7:0] w3);
        bus.word_in = {w3, w2, w1, w0};
    endtask

    // Grant edge, 8 SCAN cycles, DONE, then one IDLE cycle.
    task automatic do_scan(input logic [3:0] rq, input bit hold,
                           input int id, input logic [7:0] w,
                           input logic [3:0] pat, input int cnt,
                           input logic [7:0] mask, input bit perturb);
        logic [3:0] g;
        g = 4'(1 << id);
        bus.req     = rq;
        bus.pattern = pat;
        step();
        chk("gnt", 32'(bus.gnt), 32'(g));
        if (!hold) bus.req = '0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) chk("gnt_clr", 32'(bus.gnt), 32'd0);
            chk("bit_valid", 32'(bus.bit_valid), 32'd1);
            chk("bit_out", 32'(bus.bit_out), 32'(w[8-c]));
            chk("match_pulse", 32'(bus.match_pulse), 32'(mask[c-1]));
            chk("done_early", 32'(bus.done), 32'd0);
            if (perturb && c == 3) begin
                bus.pattern = ~pat;
                bus.word_in = ~bus.word_in;
            end
            step();
        end
        chk("done", 32'(bus.done), 32'd1);
        chk("done_id", 32'(bus.done_id), 32'(id));
        chk("match_cnt", 32'(bus.match_cnt), 32'(cnt));
        chk("busy_done", 32'(bus.busy), 32'd1);
        chk("bv_done", 32'(bus.bit_valid), 32'd0);
        step();
        chk("done_clr", 32'(bus.done), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
        chk("cnt_hold", 32'(bus.match_cnt), 32'(cnt));
    endtask

    initial begin
        reset       = 1'b1;
        bus.req     = '0;
        bus.word_in = '0;
        bus.pattern = '0;
        step();
        step();
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_cnt", 32'(bus.match_cnt), 32'd0);
        chk("rst_id", 32'(bus.done_id), 32'd0);
        chk("rst_bit", 32'(bus.bit_out), 32'd0);
        reset = 1'b0;
        step();
        chk("idle_noreq", 32'(bus.busy), 32'd0);

        // 1101_1011 vs 1101: matches end on bits 4 and 7.
        set_words(8'hDB, 8'hFF, 8'h0D, 8'hDD);
        do_scan(4'b0001, 1'b0, 0, 8'hDB, 4'hD, 2, 8'b0100_1000, 1'b0);
        // All ones vs 1111: overlap maximum of 5.
        set_words(8'hFF, 8'hFF, 8'h0D, 8'hDD);
        do_scan(4'b0001, 1'b0, 0, 8'hFF, 4'hF, 5, 8'b1111_1000, 1'b0);
        set_words(8'h00, 8'hFF, 8'h0D, 8'hDD);
        do_scan(4'b0001, 1'b0, 0, 8'h00, 4'hF, 0, 8'h00, 1'b0);

        // Held all-request rotates 0,1,2,3,0 at a 10-cycle period.
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        set_words(8'hDB, 8'hFF, 8'h0D, 8'hDD);
        do_scan(4'b1111, 1'b1, 0, 8'hDB, 4'hD, 2, 8'b0100_1000, 1'b0);
        do_scan(4'b1111, 1'b1, 1, 8'hFF, 4'hD, 0, 8'h00, 1'b0);
        do_scan(4'b1111, 1'b1, 2, 8'h0D, 4'hD, 1, 8'b1000_0000, 1'b0);
        do_scan(4'b1111, 1'b1, 3, 8'hDD, 4'hD, 2, 8'b1000_1000, 1'b0);
        do_scan(4'b1111, 1'b0, 0, 8'hDB, 4'hD, 2, 8'b0100_1000, 1'b0);

        // Pointer wraps after requester 3.
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        do_scan(4'b1000, 1'b0, 3, 8'hDD, 4'hD, 2, 8'b1000_1000, 1'b0);
        do_scan(4'b1001, 1'b0, 0, 8'hDB, 4'hD, 2, 8'b0100_1000, 1'b0);

        // Word and pattern flipped mid-scan; latched values rule.
        set_words(8'hDB, 8'hDB, 8'h0D, 8'hDD);
        do_scan(4'b0010, 1'b0, 1, 8'hDB, 4'hD, 2, 8'b0100_1000, 1'b1);

        // Reset on SCAN cycle 3 of a grant to requester 2.
        set_words(8'hDB, 8'hDB, 8'hFF, 8'hDD);
        bus.pattern = 4'hF;
        bus.req     = 4'b0100;
        step();
        chk("g2", 32'(bus.gnt), 32'b0100);
        bus.req = '0;
        step();
        step();
        chk("pre_rst_bit", 32'(bus.bit_out), 32'd1);
        chk("pre_rst_id", 32'(bus.done_id), 32'd2);
        reset = 1'b1;
        #1;
        chk("ar_gnt", 32'(bus.gnt), 32'd0);
        chk("ar_busy", 32'(bus.busy), 32'd0);
        chk("ar_bv", 32'(bus.bit_valid), 32'd0);
        chk("ar_bit", 32'(bus.bit_out), 32'd0);
        chk("ar_mp", 32'(bus.match_pulse), 32'd0);
        chk("ar_done", 32'(bus.done), 32'd0);
        chk("ar_cnt", 32'(bus.match_cnt), 32'd0);
        chk("ar_id", 32'(bus.done_id), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("ar_nodone", 32'(bus.done), 32'd0);
        end
        reset = 1'b0;
        step();
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        // Pointer back at 0 picks 1 ahead of 3.
        do_scan(4'b1010, 1'b0, 1, 8'hDB, 4'hD, 2, 8'b0100_1000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
